serial_parity_checker: RTL and testbench
========================================

Name: serial_parity_checker

Overview:
- Bit-serial receiver that rebuilds a data word from a 1-bit stream and checks it against a trailing parity bit.
- Parity is accumulated with a running 2-input XOR, using the team's XOR primitive as the accumulator cell.
- Sits directly downstream of the XOR stage and delivers checked words to the next consumer over a valid/ready interface.
- Keeps a saturating count of parity errors.

Parameters:
- DATA_BITS, 8, data bits per frame (must be at least 2).
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  sole clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial bit. A frame is DATA_BITS data bits, LSB first, followed by one parity bit.
- in_ready  output  1  block accepts in_bit this cycle.
- out_valid  output  1  checked word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_BITS  received data word.
- out_parity_err  output  1  1 when the received frame fails the parity check.
- err_count  output  ERR_CNT_W  saturating count of failed frames.

Behaviour:
- Reset (rst high at a clock edge):
  - state=RECV, bit counter=0, parity accumulator=0, shift register=0.
  - out_valid=0, out_data=0, out_parity_err=0, err_count=0.
  - Reset wins over every other event, including mid-frame and while a result is held.
  - Any partial frame is discarded.
- in_ready is combinational and equals (state==RECV). It is 1 in the first cycle after reset.
- A bit is accepted when in_valid && in_ready.
- State RECV, counter k < DATA_BITS, bit accepted:
  - shift register bit k <= in_bit.
  - acc <= acc ^ in_bit.
  - k <= k+1.
- State RECV, k == DATA_BITS, bit accepted (this is the parity bit):
  - out_data <= shift register.
  - out_parity_err <= ((acc ^ in_bit) != PARITY_ODD).
  - out_valid <= 1.
  - k <= 0, acc <= 0.
  - state <= HOLD.
  - If the frame failed, err_count increments; it saturates at 2^ERR_CNT_W-1 and never wraps.
- Latency: out_valid rises on the clock edge that accepts the parity bit, so it is visible in the following cycle.
- State HOLD:
  - in_ready=0; in_valid and in_bit are ignored and do not alter the frame.
  - out_data, out_parity_err and out_valid stay stable until the handshake.
  - out_valid && out_ready at an edge: out_valid <= 0, state <= RECV.
  - There is no bypass: in_ready returns the cycle after the handshake, so the back-to-back maximum is one frame per DATA_BITS+2 cycles.
- Idle cycles (in_valid=0) in RECV hold every register. Gaps inside a frame are legal.
- out_ready is ignored while out_valid=0.
- Counter width is $clog2(DATA_BITS+1). The counter never exceeds DATA_BITS.
- out_data is not cleared after the handshake; it is only overwritten by the next completed frame.

Decomposition:
- Shared include file holds:
  - state encodings RECV=1'b0, HOLD=1'b1.
  - the LSB-first frame-order constant.
- Natural sub-module: parity_accumulator, containing the 1-bit acc register plus the XOR primitive, with clear and enable inputs.
- Everything else (shift register, counter, FSM, err_count) stays in the top module.

Test Plan:
- Even parity, frame 0xA5 (bits 1,0,1,0,0,1,0,1) then parity 0:
  - out_valid=1 the cycle after the parity bit.
  - out_data=8'hA5, out_parity_err=0, err_count=0.
- Frame 0x01 with parity 0:
  - out_parity_err=1, err_count=1.
  - A following frame 0x03 with parity 0 gives err=0 and err_count stays 1.
- Backpressure, with out_ready held low for 5 cycles after out_valid while in_valid=1 and in_bit toggles:
  - out_valid, out_data and in_ready=0 are stable for all 5 cycles.
  - Raising out_ready clears out_valid at the next edge; in_ready=1 the cycle after.
- Reset mid-frame, rst pulsed for 1 cycle after 3 accepted bits:
  - All outputs read zero.
  - The next full frame 0xFF with parity 0 gives out_data=8'hFF, err=0. No residue from the partial frame.
- Saturation, ERR_CNT_W=2, 5 consecutive bad frames:
  - err_count reads 1, 2, 3, 3, 3.
- PARITY_ODD=1, frame 0xA5:
  - parity bit 1 gives err=0.
  - parity bit 0 gives err=1.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// Shared types and constants for the serial parity checker.
// Frame order and FSM encodings live here so every file agrees.
package serial_parity_checker_pkg;

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam bit LSB_FIRST = 1'b1;

  function automatic int frame_pos(
    input int k,
    input int n
  );
    return LSB_FIRST ? k : (n - 1 - k);
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_accumulator.sv
// One-bit running parity: an XOR cell feeding a register.
// Clear has priority over enable; x_o exposes the cell output.
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_i,
  output logic acc_o,
  output logic x_o
);

  logic acc_q;
  logic acc_d;

  assign x_o   = acc_q ^ bit_i;
  assign acc_o = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = x_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial word receiver with trailing parity check,
// valid/ready output and a saturating parity-error count.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic accept;
  logic is_par;
  logic acc_unused;
  logic par_x;

  assign in_ready = (state_q == RECV);
  assign accept   = in_valid && in_ready;
  assign is_par   = (cnt_q == LAST);

  parity_accumulator u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept && is_par),
    .en    (accept && !is_par),
    .bit_i (in_bit),
    .acc_o (acc_unused),
    .x_o   (par_x)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    unique case (state_q)
      RECV: begin
        if (accept && !is_par) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (cnt_q == CW'(i)) begin
              shift_d[frame_pos(i, DATA_BITS)] = in_bit;
            end
          end
          cnt_d = cnt_q + 1'b1;
        end else if (accept) begin
          out_data_d  = shift_q;
          err_d       = (par_x != ODD);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = HOLD;
          // saturate instead of wrapping
          if ((par_x != ODD) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = RECV;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RECV;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_parity_err = err_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: three instances (even/8-bit count,
// even/2-bit count, odd parity) checked by one monitor.
module tb_serial_parity_checker;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv[3];
  logic       ib[3];
  logic       ordy[3];
  logic       ird[3];
  logic       ov[3];
  logic [7:0] od[3];
  logic       oerr[3];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  exp_t sbq[$];
  logic seen[3];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(0),
    .ERR_CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_bit(ib[0]),
    .in_ready(ird[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_parity_err(oerr[0]),
    .err_count(cnt0));

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(0),
    .ERR_CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_bit(ib[1]),
    .in_ready(ird[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_parity_err(oerr[1]),
    .err_count(cnt1));

  serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1),
    .ERR_CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_bit(ib[2]),
    .in_ready(ird[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od[2]), .out_parity_err(oerr[2]),
    .err_count(cnt2));

  function automatic logic [7:0] get_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return {6'b0, cnt1};
      default: return cnt2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // monitor: one pop per out_valid assertion
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] === 1'b1 && !seen[i]) begin
        exp_t e;
        seen[i] = 1'b1;
        if (sbq.size() == 0) begin
          chk("unexpected_out", 32'(i), 32'hFF);
        end else begin
          e = sbq.pop_front();
          chk("sb_inst", 32'(i), 32'(e.inst));
          chk("sb_data", 32'(od[i]), 32'(e.data));
          chk("sb_err", 32'(oerr[i]), 32'(e.err));
          chk("sb_cnt", 32'(get_cnt(i)), 32'(e.cnt));
        end
      end else if (ov[i] !== 1'b1) begin
        seen[i] = 1'b0;
      end
    end
  end

  task automatic drive_bit(input int i, input logic b);
    iv[i] = 1'b1;
    ib[i] = b;
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic send_frame(input int i, input logic [7:0] d,
                            input logic p, input logic e_err,
                            input logic [7:0] e_cnt,
                            input bit gap);
    exp_t e;
    e.inst = i;
    e.data = d;
    e.err  = e_err;
    e.cnt  = e_cnt;
    sbq.push_back(e);
    chk("in_ready_start", 32'(ird[i]), 32'd1);
    for (int b = 0; b < 8; b++) begin
      drive_bit(i, d[b]);
      if (gap && b == 3) begin
        @(posedge clk);
        #1;
      end
      chk("no_early_valid", 32'(ov[i]), 32'd0);
    end
    drive_bit(i, p);
    chk("latency_valid", 32'(ov[i]), 32'd1);
    if (ordy[i]) begin
      @(posedge clk);
      #1;
      chk("valid_cleared", 32'(ov[i]), 32'd0);
      chk("in_ready_back", 32'(ird[i]), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ib[i]   = 1'b0;
      ordy[i] = 1'b1;
      seen[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_data", 32'(od[0]), 32'd0);
    chk("rst_err", 32'(oerr[0]), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_in_ready", 32'(ird[0]), 32'd1);

    send_frame(0, 8'hA5, 1'b0, 1'b0, 8'd0, 1'b0);
    send_frame(0, 8'h01, 1'b0, 1'b1, 8'd1, 1'b0);
    send_frame(0, 8'h03, 1'b0, 1'b0, 8'd1, 1'b1);

    // backpressure with toggling input while held
    ordy[0] = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 8'd1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      iv[0] = 1'b1;
      ib[0] = c[0];
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(ov[0]), 32'd1);
      chk("bp_data", 32'(od[0]), 32'h3C);
      chk("bp_in_ready", 32'(ird[0]), 32'd0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(ov[0]), 32'd0);
    chk("bp_release_ready", 32'(ird[0]), 32'd1);
    chk("data_kept", 32'(od[0]), 32'h3C);

    // reset after three accepted bits
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_data", 32'(od[0]), 32'd0);
    chk("mid_rst_err", 32'(oerr[0]), 32'd0);
    chk("mid_rst_cnt", 32'(cnt0), 32'd0);
    chk("mid_rst_ready", 32'(ird[0]), 32'd1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 8'd0, 1'b0);

    send_frame(1, 8'h01, 1'b0, 1'b1, 8'd1, 1'b0);
    send_frame(1, 8'h01, 1'b0, 1'b1, 8'd2, 1'b0);
    send_frame(1, 8'h01, 1'b0, 1'b1, 8'd3, 1'b0);
    send_frame(1, 8'h01, 1'b0, 1'b1, 8'd3, 1'b0);
    send_frame(1, 8'h01, 1'b0, 1'b1, 8'd3, 1'b0);

    send_frame(2, 8'hA5, 1'b1, 1'b0, 8'd0, 1'b0);
    send_frame(2, 8'hA5, 1'b0, 1'b1, 8'd1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
